// File: rtl/lut_eval_pkg.sv
// Shared types and helpers for the programmable truth-table evaluator.
package lut_eval_pkg;

  // Controller states: idle (loads and single evaluations) or sweeping all inputs.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Largest supported number of function inputs (a 256-entry table).
  localparam int N_IN_MAX = 8;

  // Truth-table width for a given number of inputs: one bit per input vector.
  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a truth table, i.e. its minterm count.
module tt_popcount #(
  parameter  int TT_W  = 8,
  localparam int CNT_W = $clog2(TT_W) + 1
) (
  input  logic [TT_W-1:0]  tt,
  output logic [CNT_W-1:0] cnt
);

  // Sum every table bit; the width holds the all-ones case (count == TT_W).
  always_comb begin
    cnt = '0;
    for (int i = 0; i < TT_W; i++) begin
      cnt = cnt + CNT_W'(tt[i]);
    end
  end

endmodule

// File: rtl/lut_sweep_eval.sv
// Run-time loadable N-input Boolean function: single evaluations on request,
// or an autonomous sweep of all 2^N inputs streamed through a valid/ready slot.
// N_IN is expected to lie in 1..N_IN_MAX.
module lut_sweep_eval
  import lut_eval_pkg::*;
#(
  parameter  int N_IN = 3,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  input  logic [TT_W-1:0] cfg_tt,
  output logic            cfg_ready,
  input  logic            eval_valid,
  input  logic [N_IN-1:0] eval_in,
  output logic            eval_ready,
  input  logic            sweep_start,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] out_in,
  output logic            out_f,
  output logic            out_last,
  output logic            busy,
  output logic            sweep_done,
  output logic [N_IN:0]   minterm_cnt
);

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  state_t          state_q;
  state_t          state_d;
  logic [TT_W-1:0] tt;
  logic [N_IN-1:0] idx;
  logic [N_IN:0]   cfg_popcnt;
  logic            slot_free;
  logic            cfg_fire;
  logic            eval_fire;
  logic            sweep_go;
  logic            sweep_load;

  tt_popcount #(.TT_W(TT_W)) u_popcount (
    .tt  (cfg_tt),
    .cnt (cfg_popcnt)
  );

  // The single output register can take a new result when empty or being drained.
  assign slot_free = !out_valid || out_ready;

  // Next state, handshake readiness and the per-cycle action strobes.
  always_comb begin
    state_d    = state_q;
    cfg_ready  = 1'b0;
    eval_ready = 1'b0;
    busy       = 1'b0;
    sweep_go   = 1'b0;
    sweep_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready  = 1'b1;
        eval_ready = slot_free;
        // A simultaneous table load takes priority and the start request is lost.
        sweep_go   = sweep_start && !cfg_valid;
        if (sweep_go) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        busy       = 1'b1;
        sweep_load = slot_free;
        if (sweep_load && (idx == IDX_LAST)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign eval_fire = eval_valid && eval_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Truth table and its minterm count; an eval in the same cycle still sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt          <= '0;
      minterm_cnt <= '0;
    end else if (cfg_fire) begin
      tt          <= cfg_tt;
      minterm_cnt <= cfg_popcnt;
    end
  end

  // Sweep index: restarts at zero on each sweep and advances once per emitted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (sweep_go) begin
      idx <= '0;
    end else if (sweep_load) begin
      idx <= idx + N_IN'(1);
    end
  end

  // Output slot: loaded by an eval or a sweep step, emptied when the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_in    <= '0;
      out_f     <= 1'b0;
      out_last  <= 1'b0;
    end else if (eval_fire) begin
      out_valid <= 1'b1;
      out_in    <= eval_in;
      out_f     <= tt[eval_in];
      out_last  <= 1'b0;
    end else if (sweep_load) begin
      out_valid <= 1'b1;
      out_in    <= idx;
      out_f     <= tt[idx];
      out_last  <= (idx == IDX_LAST);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle completion pulse once the final sweep entry has been consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= out_valid && out_ready && out_last;
    end
  end

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Directed bench for lut_sweep_eval at N_IN=3 and N_IN=4.
module tb_lut_sweep_eval;

  logic clk = 1'b0;
  logic rst;

  // N_IN = 3 instance
  logic       cfg_valid, cfg_ready, eval_valid, eval_ready, sweep_start;
  logic [7:0] cfg_tt;
  logic [2:0] eval_in, out_in;
  logic       out_valid, out_ready, out_f, out_last, busy, sweep_done;
  logic [3:0] minterm_cnt;

  // N_IN = 4 instance
  logic        cfg_valid4, cfg_ready4, eval_valid4, eval_ready4, sweep_start4;
  logic [15:0] cfg_tt4;
  logic [3:0]  eval_in4, out_in4;
  logic        out_valid4, out_ready4, out_f4, out_last4, busy4, sweep_done4;
  logic [4:0]  minterm_cnt4;

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic       cfg_valid;
    logic [7:0] cfg_tt;
    logic       eval_valid;
    logic [2:0] eval_in;
    logic       sweep_start;
    logic       out_ready;
    logic       exp_valid;
    logic [2:0] exp_in;
    logic       exp_f;
    logic       exp_busy;
    logic [3:0] exp_cnt;
    logic       exp_eval_ready;
  } vec_t;

  vec_t vecs[9];

  lut_sweep_eval #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_tt(cfg_tt), .cfg_ready(cfg_ready),
    .eval_valid(eval_valid), .eval_in(eval_in), .eval_ready(eval_ready),
    .sweep_start(sweep_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_in(out_in),
    .out_f(out_f), .out_last(out_last), .busy(busy),
    .sweep_done(sweep_done), .minterm_cnt(minterm_cnt)
  );

  lut_sweep_eval #(.N_IN(4)) dut4 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid4), .cfg_tt(cfg_tt4), .cfg_ready(cfg_ready4),
    .eval_valid(eval_valid4), .eval_in(eval_in4), .eval_ready(eval_ready4),
    .sweep_start(sweep_start4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_in(out_in4),
    .out_f(out_f4), .out_last(out_last4), .busy(busy4),
    .sweep_done(sweep_done4), .minterm_cnt(minterm_cnt4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failBound(input string name);
    check_cnt++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic applyStimulus(input vec_t v);
    cfg_valid   = v.cfg_valid;
    cfg_tt      = v.cfg_tt;
    eval_valid  = v.eval_valid;
    eval_in     = v.eval_in;
    sweep_start = v.sweep_start;
    out_ready   = v.out_ready;
  endtask

  initial begin
    logic [7:0]  model_tt;
    logic [15:0] model_tt4;
    logic [2:0]  exp_in_q[9];
    logic        exp_f_q[9];
    logic        exp_last_q[9];
    int          ptr;
    int          cyc;
    bit          prev_stall, prev_last_xfer, done_seen, found, bad;
    logic [2:0]  held_in;
    logic        held_f, held_last;

    // cfg_v, cfg_tt, ev_v, ev_in, start, rdy | valid, in, f, busy, cnt, eval_ready
    vecs[0] = '{1'b1, 8'h99, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 4'd4, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 4'd4, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 4'd8, 1'b1};
    vecs[5] = '{1'b1, 8'h99, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 4'd4, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 4'd4, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4, 1'b1};

    model_tt  = 8'h99;
    model_tt4 = 16'h8001;

    rst = 1'b1;
    cfg_valid = 0; cfg_tt = '0; eval_valid = 0; eval_in = '0; sweep_start = 0; out_ready = 0;
    cfg_valid4 = 0; cfg_tt4 = '0; eval_valid4 = 0; eval_in4 = '0; sweep_start4 = 0; out_ready4 = 1;
    tick();
    tick();

    // Reset state
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_in", out_in, 0);
    checkOutput("rst_out_f", out_f, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sweep_done", sweep_done, 0);
    checkOutput("rst_minterm", minterm_cnt, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_minterm4", minterm_cnt4, 0);
    rst = 1'b0;

    // Loads, evaluations and same-cycle priority cases
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d_out_in", i), out_in, vecs[i].exp_in);
        checkOutput($sformatf("v%0d_out_f", i), out_f, vecs[i].exp_f);
        checkOutput($sformatf("v%0d_out_last", i), out_last, 0);
      end
      checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      checkOutput($sformatf("v%0d_cfg_ready", i), cfg_ready, !vecs[i].exp_busy);
      checkOutput($sformatf("v%0d_eval_ready", i), eval_ready, vecs[i].exp_eval_ready);
      checkOutput($sformatf("v%0d_minterm", i), minterm_cnt, vecs[i].exp_cnt);
      checkOutput($sformatf("v%0d_sweep_done", i), sweep_done, 0);
    end
    cfg_valid = 0; eval_valid = 0; sweep_start = 0; out_ready = 1;

    // Full-rate sweep on table 0x99
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    checkOutput("sw1_busy_start", busy, 1);
    checkOutput("sw1_valid_start", out_valid, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput($sformatf("sw1_valid_%0d", c), out_valid, 1);
      checkOutput($sformatf("sw1_in_%0d", c), out_in, c[2:0]);
      checkOutput($sformatf("sw1_f_%0d", c), out_f, model_tt[c]);
      checkOutput($sformatf("sw1_last_%0d", c), out_last, (c == 7));
      checkOutput($sformatf("sw1_busy_%0d", c), busy, (c != 7));
      checkOutput($sformatf("sw1_cfg_ready_%0d", c), cfg_ready, (c == 7));
    end
    tick();
    checkOutput("sw1_done_pulse", sweep_done, 1);
    checkOutput("sw1_valid_after", out_valid, 0);
    tick();
    checkOutput("sw1_done_clear", sweep_done, 0);

    // Stalled sweep started together with an eval of input 5
    exp_in_q[0] = 3'd5; exp_f_q[0] = model_tt[5]; exp_last_q[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_in_q[i+1] = i[2:0]; exp_f_q[i+1] = model_tt[i]; exp_last_q[i+1] = (i == 7);
    end
    eval_valid = 1'b1; eval_in = 3'd5; sweep_start = 1'b1; out_ready = 1'b1;
    tick();
    eval_valid = 1'b0; sweep_start = 1'b0;
    ptr = 0; prev_stall = 0; prev_last_xfer = 0; done_seen = 0;
    held_in = '0; held_f = 0; held_last = 0;
    cyc = 0;
    while (cyc < 300 && !done_seen) begin
      out_ready = (cyc > 150) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      checkOutput("sw2_sweep_done", sweep_done, prev_last_xfer);
      if (sweep_done) done_seen = 1;
      if (prev_stall) begin
        checkOutput("sw2_hold_valid", out_valid, 1);
        checkOutput("sw2_hold_in", out_in, held_in);
        checkOutput("sw2_hold_f", out_f, held_f);
        checkOutput("sw2_hold_last", out_last, held_last);
      end
      if (busy) begin
        checkOutput("sw2_cfg_ready", cfg_ready, 0);
        checkOutput("sw2_eval_ready", eval_ready, 0);
      end
      prev_last_xfer = 0;
      if (out_valid && out_ready) begin
        if (ptr < 9) begin
          checkOutput($sformatf("sw2_in_%0d", ptr), out_in, exp_in_q[ptr]);
          checkOutput($sformatf("sw2_f_%0d", ptr), out_f, exp_f_q[ptr]);
          checkOutput($sformatf("sw2_last_%0d", ptr), out_last, exp_last_q[ptr]);
          prev_last_xfer = exp_last_q[ptr];
          ptr++;
        end else begin
          check_cnt++;
          $display("[TB] FAIL sw2_extra: got result in=%0d, expected none", out_in);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_in = out_in; held_f = out_f; held_last = out_last;
      cyc++;
      tick();
    end
    if (!done_seen) failBound("sw2_done_wait");
    checkOutput("sw2_count", ptr, 9);
    checkOutput("sw2_valid_after", out_valid, 0);
    checkOutput("sw2_busy_after", busy, 0);

    // Reset in the middle of a sweep
    out_ready = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (out_valid && out_in == 3'd4) found = 1;
    end
    if (!found) failBound("rst_mid_wait_in4");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rmid_out_valid", out_valid, 0);
    checkOutput("rmid_out_in", out_in, 0);
    checkOutput("rmid_out_f", out_f, 0);
    checkOutput("rmid_out_last", out_last, 0);
    checkOutput("rmid_busy", busy, 0);
    checkOutput("rmid_sweep_done", sweep_done, 0);
    checkOutput("rmid_minterm", minterm_cnt, 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid || sweep_done || busy) bad = 1;
    end
    checkOutput("rmid_quiet", bad, 0);
    eval_valid = 1'b1; eval_in = 3'd7;
    tick();
    eval_valid = 1'b0;
    checkOutput("rmid_eval_valid", out_valid, 1);
    checkOutput("rmid_eval_in", out_in, 7);
    checkOutput("rmid_eval_f", out_f, 0);

    // N_IN = 4: sparse table 0x8001
    cfg_valid4 = 1'b1; cfg_tt4 = model_tt4;
    tick();
    cfg_valid4 = 1'b0;
    checkOutput("n4_minterm", minterm_cnt4, 2);
    sweep_start4 = 1'b1;
    tick();
    sweep_start4 = 1'b0;
    checkOutput("n4_busy_start", busy4, 1);
    for (int c = 0; c < 16; c++) begin
      tick();
      checkOutput($sformatf("n4_valid_%0d", c), out_valid4, 1);
      checkOutput($sformatf("n4_in_%0d", c), out_in4, c[3:0]);
      checkOutput($sformatf("n4_f_%0d", c), out_f4, model_tt4[c]);
      checkOutput($sformatf("n4_last_%0d", c), out_last4, (c == 15));
    end
    tick();
    checkOutput("n4_done_pulse", sweep_done4, 1);
    checkOutput("n4_busy_after", busy4, 0);
    checkOutput("n4_valid_after", out_valid4, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/lut_sweep_eval.md
Name: lut_sweep_eval

Overview:
Parametrised, run-time programmable N-input Boolean function evaluator. Replaces fixed sum-of-minterms blocks with a loadable truth table.
- Evaluates single input vectors on request.
- Sweeps all 2^N input combinations autonomously, streaming each result through a valid/ready output.
- Reports the minterm count of the loaded table.
- Sits between a config/test controller and any consumer of function results; also serves as a built-in exhaustive self-check.

Parameters:
N_IN, 3, number of function inputs; legal range 1..8
TT_W, 2**N_IN, truth-table width (derived, not overridable)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  truth-table load request
cfg_tt  in  TT_W  truth table; bit i = F for input vector i
cfg_ready  out  1  load accepted when cfg_valid && cfg_ready
eval_valid  in  1  single-evaluation request
eval_in  in  N_IN  input vector to evaluate
eval_ready  out  1  request accepted when eval_valid && eval_ready
sweep_start  in  1  start exhaustive sweep (sampled only in IDLE)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_in  out  N_IN  input vector that produced out_f
out_f  out  1  function value tt[out_in]
out_last  out  1  result is final sweep entry (index TT_W-1)
busy  out  1  high while state == SWEEP
sweep_done  out  1  one-cycle pulse when the out_last result is accepted
minterm_cnt  out  N_IN+1  popcount of the loaded truth table

Behaviour:
- Reset: tt=0, state=IDLE, idx=0, minterm_cnt=0, and out_valid, out_in, out_f, out_last, busy, sweep_done all 0. Reset mid-sweep aborts the sweep; no further outputs and no sweep_done.
- Output slot: a single register. slot_free = !out_valid || out_ready.
- While out_valid && !out_ready: out_in, out_f and out_last hold stable.
- cfg_ready = (state==IDLE). A load writes tt at the clock edge; minterm_cnt = popcount(cfg_tt) from the next cycle.
- eval_ready = (state==IDLE) && slot_free. It must not depend on eval_valid.
- Eval latency is 1 cycle: accepted at edge k gives out_valid=1, out_in=eval_in, out_f=tt_old[eval_in], out_last=0 after edge k.
- Load and eval accepted in the same cycle: eval uses the pre-load table.
- FSM states are IDLE and SWEEP.
- IDLE -> SWEEP on sweep_start && !cfg_valid; idx is cleared to 0.
- cfg_valid && sweep_start in the same cycle: the load wins and sweep_start is dropped.
- sweep_start with an accepted eval in the same cycle: both proceed; the eval result precedes the sweep results.
- SWEEP: each cycle with slot_free, load the output slot with out_in=idx, out_f=tt[idx], out_last=(idx==TT_W-1), then increment idx.
- After loading idx TT_W-1, go SWEEP -> IDLE. idx does not wrap into a second pass.
- During SWEEP, cfg_ready=0, eval_ready=0, and sweep_start is ignored.
- sweep_done=1 for exactly one cycle, the cycle after the edge where out_valid && out_ready && out_last.
- With out_ready held at 1, a sweep streams TT_W results on consecutive cycles.
- No result is dropped or duplicated under any out_ready pattern.

Decomposition:
- Package lut_eval_pkg holds:
  - state enum {IDLE, SWEEP};
  - localparam N_IN_MAX=8;
  - a function computing TT_W from N_IN.
- Sub-module tt_popcount (parameter TT_W): combinational popcount of the table, width N_IN+1. It is instantiated once and registered in the parent.

Test Plan:
- Reset, then load cfg_tt=8'h99 (N_IN=3) -> minterm_cnt=4 next cycle. Then eval 3'b011 -> out_f=1 and eval 3'b010 -> out_f=0, each with 1-cycle latency.
- sweep_start with out_ready=1 -> 8 consecutive results, out_in 0..7, out_f=1,0,0,1,1,0,0,1. out_last on index 7, sweep_done pulse one cycle later, busy low after the last load.
- Same sweep with out_ready toggled pseudo-randomly -> exactly 8 results in order, outputs stable while stalled, cfg_ready/eval_ready=0 throughout.
- rst asserted when out_in=4 mid-sweep -> next cycle all outputs 0, tt=0, no sweep_done. A following eval 3'b111 returns out_f=0.
- Same cycle: cfg_tt=8'hFF plus eval 3'b001 on table 8'h99 -> out_f=0 (old table). Same cycle: cfg plus sweep_start -> busy stays 0, new table loaded.
- N_IN=4, cfg_tt=16'h8001 -> minterm_cnt=2. A sweep gives out_f=1 only at indices 0 and 15; out_last at index 15.
